// File: rtl/adsr_pkg.sv
// adsr_pkg: ADSR envelope state encoding and unity-level constant
package adsr_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;
  localparam logic [15:0] ENV_ONE = 16'h4000;
endpackage

// File: rtl/adsr_env_if.sv
// adsr_env_if: tick, note pulses, step/sustain settings in; envelope, valid, busy out
interface adsr_env_if #(parameter int ACC_W = 32, parameter int ENV_W = 16);
  logic             i_en;
  logic             i_note_on;
  logic             i_note_off;
  logic [ACC_W-1:0] i_attack_step;
  logic [ACC_W-1:0] i_decay_step;
  logic [ENV_W-1:0] i_sustain_lvl;
  logic [ACC_W-1:0] i_release_step;
  logic [ENV_W-1:0] o_env;
  logic             o_env_valid;
  logic             o_busy;
  modport master (
    output i_en, i_note_on, i_note_off, i_attack_step, i_decay_step, i_sustain_lvl, i_release_step,
    input  o_env, o_env_valid, o_busy
  );
  modport slave (
    input  i_en, i_note_on, i_note_off, i_attack_step, i_decay_step, i_sustain_lvl, i_release_step,
    output o_env, o_env_valid, o_busy
  );
endinterface

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator (i_clk, async i_reset_n, bus = tick/notes/steps in, Q2.14 env/valid/busy out)
module adsr_env import adsr_pkg::*; #(
  parameter int ACC_W = 32,
  parameter int ENV_W = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  adsr_env_if.slave  bus
);
  localparam logic [ACC_W:0] ONE = (ACC_W+1)'(1) << (ACC_W-2);
  adsr_state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic on_pend, off_pend, on_t, off_t;
  logic [ENV_W-1:0] sus_lvl;
  logic [ACC_W:0] sus, att_sum, dec_lim;
  always_comb begin
    on_t = on_pend | bus.i_note_on;
    off_t = off_pend | bus.i_note_off;
    sus_lvl = bus.i_sustain_lvl > ENV_W'(ENV_ONE) ? ENV_W'(ENV_ONE) : bus.i_sustain_lvl;
    sus = (ACC_W+1)'(sus_lvl) << (ACC_W-ENV_W);
    att_sum = {1'b0, acc} + {1'b0, bus.i_attack_step};
    dec_lim = sus + {1'b0, bus.i_decay_step};
    state_n = state;
    acc_n = acc;
    if (bus.i_en) begin
      if (on_t) state_n = ATTACK;
      else if (off_t && state inside {ATTACK, DECAY, SUSTAIN}) state_n = RELEASE;
      else case (state)
        IDLE: acc_n = '0;
        ATTACK: begin
          state_n = (bus.i_attack_step == '0 || att_sum >= ONE) ? DECAY : ATTACK;
          acc_n = (bus.i_attack_step == '0 || att_sum >= ONE) ? ONE[ACC_W-1:0] : att_sum[ACC_W-1:0];
        end
        DECAY: begin
          state_n = (bus.i_decay_step == '0 || {1'b0, acc} <= dec_lim) ? SUSTAIN : DECAY;
          acc_n = (bus.i_decay_step == '0 || {1'b0, acc} <= dec_lim) ? sus[ACC_W-1:0] : acc - bus.i_decay_step;
        end
        SUSTAIN: acc_n = sus[ACC_W-1:0];
        RELEASE: begin
          state_n = (bus.i_release_step == '0 || acc <= bus.i_release_step) ? IDLE : RELEASE;
          acc_n = (bus.i_release_step == '0 || acc <= bus.i_release_step) ? '0 : acc - bus.i_release_step;
        end
        default: begin
          state_n = IDLE;
          acc_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      acc <= '0;
      on_pend <= 1'b0;
      off_pend <= 1'b0;
      bus.o_env <= '0;
      bus.o_env_valid <= 1'b0;
      bus.o_busy <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      on_pend <= on_t & ~bus.i_en;
      off_pend <= off_t & ~bus.i_en;
      bus.o_env_valid <= bus.i_en;
      if (bus.i_en) begin
        bus.o_env <= acc_n[ACC_W-1 -: ENV_W];
        bus.o_busy <= state_n != IDLE;
      end
    end
  end
endmodule
